// File: rtl/tl_atomic_responder.sv
// -----------------------------------------------------------------------------
// tl_atomic_responder
//
// Home-side executor for TileLink atomics (ArithmeticData / LogicalData).
// Takes one A-channel atomic at a time, reads the addressed 64-bit beat from
// the backing store, computes the new value, writes it back under a byte
// mask and returns the old beat on D as AccessAckData. Illegal requests
// are answered with denied=1 and zero data without touching memory.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   a_*                   A-channel request (valid/ready, opcode, param,
//                         size, source, byte address, 64-bit lane data)
//   d_*                   D-channel response (valid/ready, opcode=1,
//                         source echo, denied, old beat)
//   mem_req_o/mem_we_o    memory request and direction, held until mem_gnt_i
//   mem_addr_o            beat-aligned address
//   mem_wdata_o/wmask_o   write data and byte enables
//   mem_gnt_i             memory accepts the current request
//   mem_rvalid_i/rdata_i  read return
// -----------------------------------------------------------------------------
module tl_atomic_responder #(
    parameter int ADDR_W   = 32,
    parameter int SOURCE_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                a_valid_i,
    output logic                a_ready_o,
    input  logic [2:0]          a_opcode_i,
    input  logic [2:0]          a_param_i,
    input  logic [1:0]          a_size_i,
    input  logic [SOURCE_W-1:0] a_source_i,
    input  logic [ADDR_W-1:0]   a_address_i,
    input  logic [63:0]         a_data_i,

    output logic                d_valid_o,
    input  logic                d_ready_i,
    output logic [2:0]          d_opcode_o,
    output logic [SOURCE_W-1:0] d_source_o,
    output logic                d_denied_o,
    output logic [63:0]         d_data_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [63:0]         mem_wdata_o,
    output logic [7:0]          mem_wmask_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [63:0]         mem_rdata_i
);

    localparam logic [2:0] OP_ARITH        = 3'd2;
    localparam logic [2:0] OP_LOGIC        = 3'd3;
    localparam logic [2:0] OP_ACCESSACKDAT = 3'd1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        RESP
    } state_t;

    state_t state, state_nxt;

    // Latched request. Only the beat address and the word lane are kept;
    // the low address bits matter only for the legality check at accept.
    logic                is_arith_q;
    logic [2:0]          param_q;
    logic                is_dword_q;
    logic [SOURCE_W-1:0] source_q;
    logic [ADDR_W-1:3]   beat_addr_q;
    logic                lane_q;
    logic [63:0]         operand_q;
    logic [63:0]         old_beat_q;
    logic                denied_q;

    logic                accept;
    logic                req_legal;
    logic [63:0]         wdata_calc;
    logic [7:0]          wmask_calc;

    // -------------------------------------------------------------------------
    // Atomic ALU. Word operands arrive zero-extended in [31:0]; the signed
    // compare re-extends them from bit 31 so MIN/MAX work at op width.
    // -------------------------------------------------------------------------
    function automatic logic [63:0] amo_alu(
        input logic        is_arith,
        input logic [2:0]  param,
        input logic        is_word,
        input logic [63:0] old_v,
        input logic [63:0] opr_v
    );
        logic [63:0] old_s;
        logic [63:0] opr_s;
        logic        lt_s;
        logic        lt_u;
        old_s = is_word ? {{32{old_v[31]}}, old_v[31:0]} : old_v;
        opr_s = is_word ? {{32{opr_v[31]}}, opr_v[31:0]} : opr_v;
        lt_s  = $signed(old_s) < $signed(opr_s);
        lt_u  = old_v < opr_v;
        if (is_arith) begin
            case (param)
                3'd0:    return lt_s ? old_v : opr_v;   // MIN
                3'd1:    return lt_s ? opr_v : old_v;   // MAX
                3'd2:    return lt_u ? old_v : opr_v;   // MINU
                3'd3:    return lt_u ? opr_v : old_v;   // MAXU
                3'd4:    return old_v + opr_v;          // ADD, wraps
                default: return old_v;
            endcase
        end else begin
            case (param)
                3'd0:    return old_v ^ opr_v;          // XOR
                3'd1:    return old_v | opr_v;          // OR
                3'd2:    return old_v & opr_v;          // AND
                3'd3:    return opr_v;                  // SWAP
                default: return old_v;
            endcase
        end
    endfunction

    // -------------------------------------------------------------------------
    // Legality of the request presented on A (evaluated at accept).
    // -------------------------------------------------------------------------
    always_comb begin
        logic op_ok;
        logic param_ok;
        logic size_ok;
        logic align_ok;
        op_ok    = (a_opcode_i == OP_ARITH) || (a_opcode_i == OP_LOGIC);
        param_ok = (a_opcode_i == OP_ARITH) ? (a_param_i <= 3'd4)
                                            : (a_param_i <= 3'd3);
        size_ok  = a_size_i[1];                          // 2 or 3 only
        align_ok = a_size_i[0] ? (a_address_i[2:0] == 3'b000)
                               : (a_address_i[1:0] == 2'b00);
        req_legal = op_ok && param_ok && size_ok && align_ok;
    end

    assign accept = a_valid_i && a_ready_o;

    // -------------------------------------------------------------------------
    // New beat and byte mask from the registered old beat and operand.
    // A word result lands in its own lane; the other lane re-writes old data.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [31:0] old_w;
        logic [31:0] opr_w;
        logic [63:0] res;
        old_w = lane_q ? old_beat_q[63:32] : old_beat_q[31:0];
        opr_w = lane_q ? operand_q[63:32]  : operand_q[31:0];
        if (is_dword_q) begin
            res        = amo_alu(is_arith_q, param_q, 1'b0, old_beat_q, operand_q);
            wdata_calc = res;
            wmask_calc = 8'hFF;
        end else begin
            res        = amo_alu(is_arith_q, param_q, 1'b1, {32'd0, old_w}, {32'd0, opr_w});
            wdata_calc = lane_q ? {res[31:0], old_beat_q[31:0]}
                                : {old_beat_q[63:32], res[31:0]};
            wmask_calc = lane_q ? 8'hF0 : 8'h0F;
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register.
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // Next state and outputs.
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        a_ready_o   = 1'b0;
        d_valid_o   = 1'b0;
        d_denied_o  = 1'b0;
        d_data_o    = 64'd0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = 64'd0;
        mem_wmask_o = 8'd0;
        case (state)
            IDLE: begin
                a_ready_o = 1'b1;
                if (accept) state_nxt = req_legal ? RD : RESP;
            end
            RD: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) state_nxt = RWAIT;
            end
            RWAIT: begin
                if (mem_rvalid_i) state_nxt = WR;
            end
            WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_wdata_o = wdata_calc;
                mem_wmask_o = wmask_calc;
                if (mem_gnt_i) state_nxt = RESP;   // posted write
            end
            RESP: begin
                d_valid_o  = 1'b1;
                d_denied_o = denied_q;
                d_data_o   = old_beat_q;
                if (d_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A reset drops the transaction at once: no request or response may
        // be seen during the reset cycle itself.
        if (rst_i) begin
            mem_req_o = 1'b0;
            mem_we_o  = 1'b0;
            d_valid_o = 1'b0;
        end
    end

    assign d_opcode_o = OP_ACCESSACKDAT;
    assign d_source_o = source_q;
    assign mem_addr_o = {beat_addr_q, 3'b000};

    // -------------------------------------------------------------------------
    // Request capture and read-data capture.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_arith_q  <= 1'b0;
            param_q     <= 3'd0;
            is_dword_q  <= 1'b0;
            source_q    <= '0;
            beat_addr_q <= '0;
            lane_q      <= 1'b0;
            operand_q   <= 64'd0;
            old_beat_q  <= 64'd0;
            denied_q    <= 1'b0;
        end else begin
            if (accept) begin
                is_arith_q  <= (a_opcode_i == OP_ARITH);
                param_q     <= a_param_i;
                is_dword_q  <= a_size_i[0];
                source_q    <= a_source_i;
                beat_addr_q <= a_address_i[ADDR_W-1:3];
                lane_q      <= a_address_i[2];
                operand_q   <= a_data_i;
                old_beat_q  <= 64'd0;          // a denied reply carries zero data
                denied_q    <= !req_legal;
            end
            if (state == RWAIT && mem_rvalid_i) old_beat_q <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_tl_atomic_responder.sv
// -----------------------------------------------------------------------------
// tb_tl_atomic_responder
//
// Directed bench for tl_atomic_responder. A behavioural memory with a
// programmable grant delay serves the memory port; expected writes and D
// responses are pushed to queues when a request is issued and popped when
// the DUT produces them.
// -----------------------------------------------------------------------------
module tb_tl_atomic_responder;

    localparam int ADDR_W   = 32;
    localparam int SOURCE_W = 4;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic                a_valid_i = 1'b0;
    logic                a_ready_o;
    logic [2:0]          a_opcode_i = 3'd0;
    logic [2:0]          a_param_i = 3'd0;
    logic [1:0]          a_size_i = 2'd0;
    logic [SOURCE_W-1:0] a_source_i = '0;
    logic [ADDR_W-1:0]   a_address_i = '0;
    logic [63:0]         a_data_i = 64'd0;
    logic                d_valid_o;
    logic                d_ready_i = 1'b1;
    logic [2:0]          d_opcode_o;
    logic [SOURCE_W-1:0] d_source_o;
    logic                d_denied_o;
    logic [63:0]         d_data_o;
    logic                mem_req_o;
    logic                mem_we_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [63:0]         mem_wdata_o;
    logic [7:0]          mem_wmask_o;
    logic                mem_gnt_i = 1'b0;
    logic                mem_rvalid_i = 1'b0;
    logic [63:0]         mem_rdata_i = 64'd0;

    always #5 clk = ~clk;

    tl_atomic_responder #(.ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
        .a_param_i(a_param_i), .a_size_i(a_size_i), .a_source_i(a_source_i),
        .a_address_i(a_address_i), .a_data_i(a_data_i),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
        .d_source_o(d_source_o), .d_denied_o(d_denied_o), .d_data_o(d_data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic [SOURCE_W-1:0] source;
        logic                denied;
        logic [63:0]         data;
    } d_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } w_exp_t;

    d_exp_t      exp_d[$];
    w_exp_t      exp_w[$];
    logic [63:0] mem_model [logic [31:0]];

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          gnt_delay = 0;
    bit          hold_rvalid = 1'b0;
    int          held_cnt = 0;
    bit          rd_pend = 1'b0;
    logic [63:0] rd_buf = 64'd0;
    int          n_mem_req = 0;
    bit          prev_wait = 1'b0;
    logic [104:0] prev_req = '0;
    logic [63:0] last_wdata = 64'd0;
    logic [7:0]  last_wmask = 8'd0;
    logic [63:0] last_d = 64'd0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- memory
    always @(negedge clk) begin
        logic [104:0] cur;
        w_exp_t       w;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 64'hDEAD_DEAD_DEAD_DEAD;
        if (rd_pend && !hold_rvalid) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rd_buf;
            rd_pend      = 1'b0;
        end
        if (mem_req_o) begin
            n_mem_req++;
            cur = {mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o};
            if (prev_wait) check("mem_req_stable", cur === prev_req, 1);
            if (held_cnt >= gnt_delay) begin
                mem_gnt_i = 1'b1;
                held_cnt  = 0;
                prev_wait = 1'b0;
                if (!mem_we_o) begin
                    rd_pend = 1'b1;
                    rd_buf  = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 64'd0;
                end else begin
                    check("wr_expected", exp_w.size() != 0, 1);
                    if (exp_w.size() != 0) begin
                        w = exp_w.pop_front();
                        check("wr_addr", mem_addr_o, w.addr);
                        check("wr_data", mem_wdata_o, w.wdata);
                        check("wr_mask", mem_wmask_o, w.wmask);
                    end
                    if (!mem_model.exists(mem_addr_o)) mem_model[mem_addr_o] = 64'd0;
                    for (int b = 0; b < 8; b++)
                        if (mem_wmask_o[b]) mem_model[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
                    last_wdata = mem_wdata_o;
                    last_wmask = mem_wmask_o;
                end
            end else begin
                mem_gnt_i = 1'b0;
                held_cnt++;
                prev_wait = 1'b1;
                prev_req  = cur;
            end
        end else begin
            mem_gnt_i = 1'b0;
            held_cnt  = 0;
            prev_wait = 1'b0;
        end
    end

    // ----------------------------------------------------------------- model
    function automatic logic [31:0] ref32(input logic arith, input logic [2:0] param,
                                          input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (arith) begin
            case (param)
                3'd0: return (sa > sb) ? b : a;
                3'd1: return (sa > sb) ? a : b;
                3'd2: return (a > b) ? b : a;
                3'd3: return (a > b) ? a : b;
                default: return a + b;
            endcase
        end
        case (param)
            3'd0: return a ^ b;
            3'd1: return a | b;
            3'd2: return a & b;
            default: return b;
        endcase
    endfunction

    function automatic logic [63:0] ref64(input logic arith, input logic [2:0] param,
                                          input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        sa = a;
        sb = b;
        if (arith) begin
            case (param)
                3'd0: return (sa > sb) ? b : a;
                3'd1: return (sa > sb) ? a : b;
                3'd2: return (a > b) ? b : a;
                3'd3: return (a > b) ? a : b;
                default: return a + b;
            endcase
        end
        case (param)
            3'd0: return a ^ b;
            3'd1: return a | b;
            3'd2: return a & b;
            default: return b;
        endcase
    endfunction

    task automatic model(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                         input logic [3:0] src, input logic [31:0] addr, input logic [63:0] data);
        logic [31:0] beat;
        logic [63:0] old, wd;
        logic [31:0] r32;
        bit          legal;
        beat  = {addr[31:3], 3'b000};
        old   = mem_model.exists(beat) ? mem_model[beat] : 64'd0;
        legal = ((op == 3'd2 && param <= 3'd4) || (op == 3'd3 && param <= 3'd3))
                && (size == 2'd2 || size == 2'd3)
                && ((addr % (32'd1 << size)) == 0);
        if (!legal) begin
            exp_d.push_back('{src, 1'b1, 64'd0});
        end else if (size == 2'd3) begin
            exp_w.push_back('{beat, ref64(op == 3'd2, param, old, data), 8'hFF});
            exp_d.push_back('{src, 1'b0, old});
        end else begin
            wd = old;
            if (addr[2]) begin
                r32 = ref32(op == 3'd2, param, old[63:32], data[63:32]);
                wd[63:32] = r32;
                exp_w.push_back('{beat, wd, 8'hF0});
            end else begin
                r32 = ref32(op == 3'd2, param, old[31:0], data[31:0]);
                wd[31:0] = r32;
                exp_w.push_back('{beat, wd, 8'h0F});
            end
            exp_d.push_back('{src, 1'b0, old});
        end
    endtask

    // ------------------------------------------------------------- stimulus
    task automatic send(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                        input logic [3:0] src, input logic [31:0] addr, input logic [63:0] data,
                        input bit expect_it, output int acc);
        @(negedge clk);
        a_opcode_i = op; a_param_i = param; a_size_i = size;
        a_source_i = src; a_address_i = addr; a_data_i = data;
        a_valid_i = 1'b1;
        for (int i = 0; i < 50 && !a_ready_o; i++) @(negedge clk);
        check("a_ready_seen", a_ready_o, 1);
        acc = cyc;
        if (expect_it) model(op, param, size, src, addr, data);
        @(negedge clk);
        a_valid_i = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int acc, input int lat, input int hold);
        d_exp_t e;
        logic [63:0] snap;
        for (int i = 0; i < 60 && !d_valid_o; i++) @(negedge clk);
        check({tag, "_dvalid"}, d_valid_o, 1);
        check({tag, "_latency"}, cyc - acc, lat);
        check({tag, "_dq"}, exp_d.size() != 0, 1);
        last_d = d_data_o;
        if (exp_d.size() != 0) begin
            e = exp_d.pop_front();
            check({tag, "_dsource"}, d_source_o, e.source);
            check({tag, "_ddenied"}, d_denied_o, e.denied);
            check({tag, "_ddata"}, d_data_o, e.data);
            check({tag, "_dopcode"}, d_opcode_o, 3'd1);
        end
        snap = {d_data_o};
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, d_valid_o, 1);
            check({tag, "_hold_data"}, d_data_o, snap);
            check({tag, "_hold_src"}, d_source_o, e.source);
            check({tag, "_hold_aready"}, a_ready_o, 0);
        end
        d_ready_i = 1'b1;
        check({tag, "_aready_in_hs"}, a_ready_o, 0);
        @(negedge clk);
        check({tag, "_aready_after"}, a_ready_o, 1);
        check({tag, "_dvalid_drop"}, d_valid_o, 0);
        check({tag, "_wq_empty"}, exp_w.size(), 0);
    endtask

    initial begin
        int acc;
        int req_before;

        // reset state
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_a_ready", a_ready_o, 1);
        check("rst_d_valid", d_valid_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_we", mem_we_o, 0);
        check("rst_denied", d_denied_o, 0);
        check("rst_d_data", d_data_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_wmask", mem_wmask_o, 0);
        rst_i = 1'b0;

        // ADD.D carry across the word boundary
        mem_model[32'h100] = 64'h0000_0000_FFFF_FFFF;
        send(3'd2, 3'd4, 2'd3, 4'd1, 32'h100, 64'd1, 1, acc);
        wait_resp("add_d", acc, 4, 0);
        check("add_d_wdata", last_wdata, 64'h0000_0001_0000_0000);
        check("add_d_wmask", last_wmask, 8'hFF);
        check("add_d_old", last_d, 64'h0000_0000_FFFF_FFFF);

        // MAX.W upper lane, negative old value
        mem_model[32'h100] = 64'h8000_0000_1234_5678;
        send(3'd2, 3'd1, 2'd2, 4'd2, 32'h104, 64'h0000_0005_0000_0000, 1, acc);
        wait_resp("max_w", acc, 4, 0);
        check("max_w_wdata", last_wdata, 64'h0000_0005_1234_5678);
        check("max_w_wmask", last_wmask, 8'hF0);
        check("max_w_old", last_d, 64'h8000_0000_1234_5678);

        // MINU.W then MIN.W on the same values
        mem_model[32'h100] = 64'hAAAA_AAAA_FFFF_FFFF;
        send(3'd2, 3'd2, 2'd2, 4'd3, 32'h100, 64'h0000_0000_0000_0002, 1, acc);
        wait_resp("minu_w", acc, 4, 0);
        check("minu_w_wdata", last_wdata, 64'hAAAA_AAAA_0000_0002);
        check("minu_w_wmask", last_wmask, 8'h0F);
        mem_model[32'h100] = 64'hAAAA_AAAA_FFFF_FFFF;
        send(3'd2, 3'd0, 2'd2, 4'd3, 32'h100, 64'h0000_0000_0000_0002, 1, acc);
        wait_resp("min_w", acc, 4, 0);
        check("min_w_wdata", last_wdata, 64'hAAAA_AAAA_FFFF_FFFF);

        // SWAP.D with D back-pressure
        mem_model[32'h200] = 64'h1122_3344_5566_7788;
        d_ready_i = 1'b0;
        send(3'd3, 3'd3, 2'd3, 4'd9, 32'h200, 64'hDEAD_BEEF_CAFE_F00D, 1, acc);
        wait_resp("swap_d", acc, 4, 5);
        check("swap_d_wdata", last_wdata, 64'hDEAD_BEEF_CAFE_F00D);

        // more operations through the model
        mem_model[32'h208] = 64'h8000_0000_0000_0000;
        send(3'd2, 3'd3, 2'd3, 4'd4, 32'h208, 64'd1, 1, acc);            // MAXU.D
        wait_resp("maxu_d", acc, 4, 0);
        mem_model[32'h208] = 64'hFFFF_FFFF_FFFF_FFFF;
        send(3'd2, 3'd1, 2'd3, 4'd4, 32'h208, 64'd7, 1, acc);            // MAX.D
        wait_resp("max_d", acc, 4, 0);
        mem_model[32'h208] = 64'hFFFF_FFFF_0BAD_F00D;
        send(3'd2, 3'd4, 2'd2, 4'd6, 32'h20C, 64'h0000_0003_FFFF_FFFF, 1, acc); // ADD.W wrap
        wait_resp("add_w", acc, 4, 0);
        check("add_w_wdata", last_wdata, 64'h0000_0002_0BAD_F00D);
        send(3'd3, 3'd2, 2'd2, 4'd7, 32'h208, 64'hFFFF_FFFF_0000_FFFF, 1, acc); // AND.W
        wait_resp("and_w", acc, 4, 0);
        send(3'd3, 3'd0, 2'd3, 4'd8, 32'h208, 64'hF0F0_F0F0_F0F0_F0F0, 1, acc); // XOR.D
        wait_resp("xor_d", acc, 4, 0);

        // denied requests: no memory traffic, response one cycle after accept
        req_before = n_mem_req;
        send(3'd3, 3'd5, 2'd3, 4'd10, 32'h100, 64'd5, 1, acc);           // logical param 5
        wait_resp("deny_param", acc, 1, 0);
        send(3'd2, 3'd4, 2'd3, 4'd11, 32'h104, 64'd5, 1, acc);           // misaligned dword
        wait_resp("deny_align", acc, 1, 0);
        send(3'd2, 3'd4, 2'd2, 4'd12, 32'h102, 64'd5, 1, acc);           // misaligned word
        wait_resp("deny_walign", acc, 1, 0);
        send(3'd2, 3'd0, 2'd1, 4'd13, 32'h100, 64'd5, 1, acc);           // size 1
        wait_resp("deny_size", acc, 1, 0);
        send(3'd0, 3'd0, 2'd3, 4'd14, 32'h100, 64'd5, 1, acc);           // bad opcode
        wait_resp("deny_op", acc, 1, 0);
        check("deny_no_mem", n_mem_req, req_before);

        // grant withheld 3 cycles in both RD and WR
        gnt_delay  = 3;
        req_before = n_mem_req;
        mem_model[32'h108] = 64'h0101_0101_2020_2020;
        send(3'd3, 3'd1, 2'd2, 4'd5, 32'h10C, 64'h8000_0008_0000_0000, 1, acc); // OR.W lane 1
        wait_resp("gnt_wait", acc, 10, 0);
        check("gnt_wait_req_cycles", n_mem_req - req_before, 8);
        check("gnt_wait_wdata", last_wdata, 64'h8101_0109_2020_2020);

        // reset while RD is waiting for a grant
        gnt_delay = 100;
        send(3'd2, 3'd4, 2'd3, 4'd1, 32'h300, 64'd1, 0, acc);
        check("rstrd_req_before", mem_req_o, 1);
        rst_i = 1'b1;
        #1;
        check("rstrd_req_in_reset", mem_req_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        check("rstrd_idle", a_ready_o, 1);
        check("rstrd_no_req", mem_req_o, 0);
        gnt_delay = 0;

        // reset while in RWAIT, then a late read return
        hold_rvalid = 1'b1;
        mem_model[32'h300] = 64'h0F0F_0F0F_0F0F_0F0F;
        send(3'd2, 3'd4, 2'd3, 4'd2, 32'h300, 64'd1, 0, acc);
        @(negedge clk);
        check("rstrw_in_rwait", mem_req_o, 0);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("rstrw_idle", a_ready_o, 1);
        check("rstrw_no_d", d_valid_o, 0);
        hold_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstrw_quiet_d", d_valid_o, 0);
            check("rstrw_quiet_req", mem_req_o, 0);
        end

        // normal operation afterwards uses fresh read data
        mem_model[32'h300] = 64'h1234_0000_0000_4321;
        send(3'd3, 3'd0, 2'd3, 4'd15, 32'h300, 64'hFFFF_0000_0000_FFFF, 1, acc);
        wait_resp("recover", acc, 4, 0);
        check("recover_wdata", last_wdata, 64'hEDCB_0000_0000_BCDE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
